// File: rtl/avg_pkg.sv
// Shared definitions for the avg_pipe streaming averager.
// Holds the default parameter values, the ceil-log2 helper and the
// derived width formulas used by the pipeline.
package avg_pkg;

    // Ceiling log2 that can be evaluated at elaboration time.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int AVG_WIDTH        = 16;
    localparam int AVG_NUM_IN       = 8;
    localparam int AVG_MAX_WIN_LOG2 = 4;

    // Tree depth, and the accumulator width that can hold a full window
    // of full-scale samples without overflow.
    localparam int AVG_LOG2N = clog2(AVG_NUM_IN);
    localparam int AVG_SUM_W = AVG_WIDTH + AVG_LOG2N + AVG_MAX_WIN_LOG2;

endpackage

// File: rtl/avg_add_stage.sv
// One registered level of the adder tree: sums PAIRS adjacent operand
// pairs and registers the results together with a valid bit.
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset (clears valid and data)
//   i_clr    synchronous flush (clears valid only)
//   i_hold   stall; all registers keep their value
//   i_valid  valid bit travelling with i_data
//   i_data   2*PAIRS operands of IN_W bits each
//   o_valid  registered valid
//   o_data   PAIRS registered sums of IN_W bits each
module avg_add_stage #(
    parameter int IN_W  = 16,
    parameter int PAIRS = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clr,
    input  logic                    i_hold,
    input  logic                    i_valid,
    input  logic [2*PAIRS*IN_W-1:0] i_data,
    output logic                    o_valid,
    output logic [PAIRS*IN_W-1:0]   o_data
);

    logic [PAIRS*IN_W-1:0] w_sum;

    // Operands are already sign-extended to the full width, so a plain
    // modular add is exact.
    always_comb begin
        w_sum = '0;
        for (int p = 0; p < PAIRS; p++) begin
            w_sum[p*IN_W +: IN_W] = i_data[(2*p)*IN_W +: IN_W]
                                  + i_data[(2*p+1)*IN_W +: IN_W];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (i_clr) begin
            o_valid <= 1'b0;
        end else if (!i_hold) begin
            o_valid <= i_valid;
            o_data  <= w_sum;
        end
    end

endmodule

// File: rtl/avg_pipe.sv
// Streaming signed averager. Each accepted beat carries NUM_IN signed
// samples; they are summed by a registered adder tree, accumulated over
// 2^win_log2 beats and divided by an arithmetic right shift.
// Pipeline: input register, LOG2N tree levels, window accumulator,
// output register (valid/ready).
// Optional feature: define AVG_ROUND_EN for round-half-up; otherwise the
// result is floored.
// Ports:
//   CLK, RST    clock, synchronous active-high reset
//   clr         flush partial window and in-flight data
//   win_log2    log2 of beats per output (clamped to MAX_WIN_LOG2)
//   in_valid/in_ready/in_data     input beat handshake
//   out_valid/out_ready/out_data  average handshake
module avg_pipe
    import avg_pkg::*;
#(
    parameter int WIDTH        = AVG_WIDTH,
    parameter int NUM_IN       = AVG_NUM_IN,
    parameter int MAX_WIN_LOG2 = AVG_MAX_WIN_LOG2
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  clr,
    input  logic [clog2(MAX_WIN_LOG2+1)-1:0]      win_log2,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_IN*WIDTH-1:0]               in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [WIDTH-1:0]                      out_data
);

    localparam int LOG2N = clog2(NUM_IN);
    localparam int SUM_W = WIDTH + LOG2N + MAX_WIN_LOG2;
    localparam int WIN_W = clog2(MAX_WIN_LOG2 + 1);
    localparam int CNT_W = (MAX_WIN_LOG2 < 1) ? 1 : MAX_WIN_LOG2;
    localparam int SH_W  = clog2(LOG2N + MAX_WIN_LOG2 + 1);

    logic                      w_stall;
    logic [NUM_IN*SUM_W-1:0]   w_ext;
    logic                      r_in_v;
    logic [NUM_IN*SUM_W-1:0]   r_in_data;
    logic signed [SUM_W-1:0]   w_tree;
    logic                      w_tree_v;
    logic [WIN_W-1:0]          w_win_in;
    logic [WIN_W-1:0]          w_win_eff;
    logic [CNT_W-1:0]          w_last;
    logic signed [SUM_W-1:0]   w_acc_next;
    logic signed [SUM_W-1:0]   w_rnd;
    logic signed [SUM_W-1:0]   r_acc;
    logic [CNT_W-1:0]          r_cnt;
    logic [WIN_W-1:0]          r_win_q;
    logic                      r_tot_v;
    logic signed [SUM_W-1:0]   r_tot;
    logic [SH_W-1:0]           r_tot_s;
    logic                      r_out_valid;
    logic [WIDTH-1:0]          r_out_data;

    assign w_stall   = r_out_valid && !out_ready;
    assign in_ready  = !w_stall && !RST;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    always_comb begin
        w_ext = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_ext[k*SUM_W +: SUM_W] = {{(SUM_W-WIDTH){in_data[k*WIDTH+WIDTH-1]}},
                                       in_data[k*WIDTH +: WIDTH]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_in_v    <= 1'b0;
            r_in_data <= '0;
        end else if (clr) begin
            r_in_v    <= 1'b0;
        end else if (!w_stall) begin
            r_in_v    <= in_valid && in_ready;
            r_in_data <= w_ext;
        end
    end

    for (genvar j = 0; j < LOG2N; j++) begin : g_lvl
        localparam int P = NUM_IN >> (j + 1);
        logic [2*P*SUM_W-1:0] w_src;
        logic                 w_src_v;
        logic [P*SUM_W-1:0]   w_sum;
        logic                 w_sum_v;

        if (j == 0) begin : g_first
            assign w_src   = r_in_data;
            assign w_src_v = r_in_v;
        end else begin : g_next
            assign w_src   = g_lvl[j-1].w_sum;
            assign w_src_v = g_lvl[j-1].w_sum_v;
        end

        avg_add_stage #(
            .IN_W  (SUM_W),
            .PAIRS (P)
        ) u_stage (
            .i_clk   (CLK),
            .i_rst   (RST),
            .i_clr   (clr),
            .i_hold  (w_stall),
            .i_valid (w_src_v),
            .i_data  (w_src),
            .o_valid (w_sum_v),
            .o_data  (w_sum)
        );
    end

    assign w_tree   = g_lvl[LOG2N-1].w_sum;
    assign w_tree_v = g_lvl[LOG2N-1].w_sum_v;

    // The window length is taken live on the first beat of a window and
    // frozen in r_win_q for the rest of it.
    assign w_win_in   = (win_log2 > WIN_W'(MAX_WIN_LOG2)) ? WIN_W'(MAX_WIN_LOG2) : win_log2;
    assign w_win_eff  = (r_cnt == '0) ? w_win_in : r_win_q;
    assign w_last     = CNT_W'((32'd1 << w_win_eff) - 32'd1);
    assign w_acc_next = (r_cnt == '0) ? w_tree : r_acc + w_tree;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_win_q <= '0;
            r_tot_v <= 1'b0;
            r_tot   <= '0;
            r_tot_s <= '0;
        end else if (clr) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_tot_v <= 1'b0;
        end else if (!w_stall) begin
            r_tot_v <= 1'b0;
            if (w_tree_v) begin
                r_acc <= w_acc_next;
                if (r_cnt == '0) begin
                    r_win_q <= w_win_in;
                end
                if (r_cnt == w_last) begin
                    r_cnt   <= '0;
                    r_tot   <= w_acc_next;
                    r_tot_v <= 1'b1;
                    // Shift travels with the total so a new window cannot
                    // disturb it.
                    r_tot_s <= SH_W'(LOG2N) + SH_W'(w_win_eff);
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef AVG_ROUND_EN
    // Shift is never zero (NUM_IN >= 2), so the half-LSB term is defined.
    assign w_rnd = r_tot + (SUM_W'(1) << (r_tot_s - SH_W'(1)));
`else
    assign w_rnd = r_tot;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (clr) begin
            r_out_valid <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= r_tot_v;
            if (r_tot_v) begin
                r_out_data <= WIDTH'(w_rnd >>> r_tot_s);
            end
        end
    end

endmodule

// File: tb/tb_avg_pipe.sv
module tb_avg_pipe;

    localparam int WIDTH  = 16;
    localparam int NUM_IN = 8;
    localparam int MAXW   = 4;
    localparam int WIN_W  = 3;

    logic                    CLK = 1'b0;
    logic                    RST;
    logic                    clr;
    logic [WIN_W-1:0]        win_log2;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     vcount = 0;
    int     got_q[$];
    int     exp_q[$];
    int     got_base = 0;
    longint m_acc = 0;
    int     m_cnt = 0;
    int     m_w = 0;
    int     last_acc_cyc = 0;
    bit     rnd_rdy = 1'b0;

    avg_pipe #(
        .WIDTH        (WIDTH),
        .NUM_IN       (NUM_IN),
        .MAX_WIN_LOG2 (MAXW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .clr       (clr),
        .win_log2  (win_log2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (out_valid) vcount <= vcount + 1;
        if (out_valid && out_ready) got_q.push_back(int'($signed(out_data)));
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    // Reference: average = floor(total / (NUM_IN * 2^w)), or
    // floor((total + half) / divisor) when rounding is enabled.
    function automatic int exp_avg(input longint tot, input int w);
        longint dv, t, q;
        dv = longint'(NUM_IN) << w;
        t  = tot;
`ifdef AVG_ROUND_EN
        t = t + dv / 2;
`endif
        q = t / dv;
        if ((t % dv) != 0 && t < 0) q = q - 1;
        return int'(q);
    endfunction

    function automatic logic [NUM_IN*WIDTH-1:0] fill(input int v);
        logic [NUM_IN*WIDTH-1:0] d;
        for (int k = 0; k < NUM_IN; k++) d[k*WIDTH +: WIDTH] = WIDTH'(v);
        return d;
    endfunction

    function automatic logic [NUM_IN*WIDTH-1:0] rand_beat();
        logic [NUM_IN*WIDTH-1:0] d;
        for (int k = 0; k < NUM_IN; k++) d[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        return d;
    endfunction

    task automatic model_beat(input logic [NUM_IN*WIDTH-1:0] d);
        longint s;
        s = 0;
        for (int k = 0; k < NUM_IN; k++) s += longint'($signed(d[k*WIDTH +: WIDTH]));
        if (m_cnt == 0) m_w = (int'(win_log2) > MAXW) ? MAXW : int'(win_log2);
        m_acc += s;
        m_cnt++;
        if (m_cnt == (1 << m_w)) begin
            exp_q.push_back(exp_avg(m_acc, m_w));
            m_acc = 0;
            m_cnt = 0;
        end
    endtask

    task automatic model_flush();
        m_acc = 0;
        m_cnt = 0;
        exp_q.delete();
        got_base = got_q.size();
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_beat(input logic [NUM_IN*WIDTH-1:0] d);
        int  waited;
        bit  done;
        waited   = 0;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        while (!done) begin
            @(negedge CLK);
            if (in_ready) begin
                model_beat(d);
                done = 1'b1;
            end
            tick();
            if (done) last_acc_cyc = cyc;
            waited++;
            if (!done && waited > 300) begin
                checks++;
                errors++;
                $display("FAIL send_beat in_ready stuck low after %0d cycles", waited);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_outputs(input int n);
        for (int i = 0; i < 400 && (got_q.size() - got_base) < n; i++) tick();
        repeat (10) tick();
    endtask

    task automatic test_reset();
        RST = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1; win_log2 = '0;
        repeat (3) tick();
        @(negedge CLK);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%0h want=0", out_data); end
        tick();
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
        tick();
    endtask

    task automatic test_latency();
        int lat, val, acc;
        model_flush();
        win_log2 = 3'd0; out_ready = 1'b1;
        send_beat(fill(100));
        acc = last_acc_cyc;
        lat = -1; val = 0;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(negedge CLK);
            if (out_valid) begin lat = cyc - acc; val = int'($signed(out_data)); end
            @(posedge CLK); #1;
        end
        checks++; if (lat !== 5) begin errors++; $display("FAIL latency got=%0d want=5", lat); end
        checks++; if (val !== 100) begin errors++; $display("FAIL avg100 got=%0d want=100", val); end
        @(negedge CLK);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pulse out_valid got=%b want=0", out_valid); end
        tick();
    endtask

    task automatic test_negative();
        logic [NUM_IN*WIDTH-1:0] d;
        int want;
`ifdef AVG_ROUND_EN
        want = -4;
`else
        want = -5;
`endif
        model_flush();
        win_log2 = 3'd0;
        for (int k = 0; k < NUM_IN; k++) d[k*WIDTH +: WIDTH] = WIDTH'(-(k + 1));
        send_beat(d);
        wait_outputs(1);
        checks++; if (got_q.size() - got_base !== 1) begin errors++; $display("FAIL neg_count got=%0d want=1", got_q.size() - got_base); end
        if (got_q.size() > got_base) begin
            checks++; if (got_q[got_base] !== want) begin errors++; $display("FAIL neg_avg got=%0d want=%0d", got_q[got_base], want); end
            checks++; if (got_q[got_base] !== exp_q[0]) begin errors++; $display("FAIL neg_model got=%0d want=%0d", got_q[got_base], exp_q[0]); end
        end
    endtask

    task automatic test_extremes();
        model_flush();
        win_log2 = 3'd0;
        send_beat(fill(32767));
        send_beat(fill(-32768));
        wait_outputs(2);
        checks++; if (got_q.size() - got_base !== 2) begin errors++; $display("FAIL ext_count got=%0d want=2", got_q.size() - got_base); end
        if (got_q.size() >= got_base + 2) begin
            checks++; if (got_q[got_base] !== 32767) begin errors++; $display("FAIL ext_max got=%0d want=32767", got_q[got_base]); end
            checks++; if (got_q[got_base+1] !== -32768) begin errors++; $display("FAIL ext_min got=%0d want=-32768", got_q[got_base+1]); end
        end
    endtask

    task automatic test_window();
        model_flush();
        win_log2 = 3'd2;
        send_beat(fill(10));
        send_beat(fill(20));
        send_beat(fill(30));
        repeat (12) tick();
        checks++; if (got_q.size() - got_base !== 0) begin errors++; $display("FAIL win_early got=%0d want=0", got_q.size() - got_base); end
        send_beat(fill(40));
        wait_outputs(1);
        checks++; if (got_q.size() - got_base !== 1) begin errors++; $display("FAIL win_count got=%0d want=1", got_q.size() - got_base); end
        if (got_q.size() > got_base) begin
            checks++; if (got_q[got_base] !== 25) begin errors++; $display("FAIL win_avg got=%0d want=25", got_q[got_base]); end
        end
    endtask

    task automatic test_clamp();
        model_flush();
        win_log2 = 3'd7;
        for (int i = 0; i < 15; i++) send_beat(rand_beat());
        repeat (12) tick();
        checks++; if (got_q.size() - got_base !== 0) begin errors++; $display("FAIL clamp_early got=%0d want=0", got_q.size() - got_base); end
        send_beat(rand_beat());
        wait_outputs(1);
        checks++; if (got_q.size() - got_base !== 1) begin errors++; $display("FAIL clamp_count got=%0d want=1", got_q.size() - got_base); end
        if (got_q.size() > got_base) begin
            checks++; if (got_q[got_base] !== exp_q[0]) begin errors++; $display("FAIL clamp_avg got=%0d want=%0d", got_q[got_base], exp_q[0]); end
        end
    endtask

    task automatic test_back_to_back();
        int first_cyc, held;
        model_flush();
        win_log2 = 3'd0; out_ready = 1'b0;
        send_beat(rand_beat());
        first_cyc = last_acc_cyc;
        for (int i = 0; i < 5; i++) send_beat(rand_beat());
        checks++; if (last_acc_cyc - first_cyc !== 5) begin errors++; $display("FAIL bp_accept_span got=%0d want=5", last_acc_cyc - first_cyc); end
        @(negedge CLK);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got=%b want=1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        held = int'($signed(out_data));
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge CLK);
            checks++; if (int'($signed(out_data)) !== held) begin errors++; $display("FAIL bp_stable got=%0d want=%0d", $signed(out_data), held); end
        end
        tick();
        out_ready = 1'b1;
        wait_outputs(6);
        checks++; if (got_q.size() - got_base !== 6) begin errors++; $display("FAIL bp_count got=%0d want=6", got_q.size() - got_base); end
        for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++) begin
            checks++; if (got_q[got_base+i] !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d] got=%0d want=%0d", i, got_q[got_base+i], exp_q[i]); end
        end
    endtask

    task automatic test_abort(input bit use_clr);
        int vc;
        model_flush();
        win_log2 = 3'd3; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_beat(rand_beat());
        vc = vcount;
        if (use_clr) clr = 1'b1; else RST = 1'b1;
        tick();
        clr = 1'b0; RST = 1'b0;
        model_flush();
        repeat (20) tick();
        checks++; if (vcount !== vc) begin errors++; $display("FAIL abort_no_valid clr=%0d got=%0d want=%0d", use_clr, vcount - vc, 0); end
        for (int i = 0; i < 8; i++) send_beat(fill(7));
        wait_outputs(1);
        checks++; if (got_q.size() - got_base !== 1) begin errors++; $display("FAIL abort_count clr=%0d got=%0d want=1", use_clr, got_q.size() - got_base); end
        if (got_q.size() > got_base) begin
            checks++; if (got_q[got_base] !== 7) begin errors++; $display("FAIL abort_avg clr=%0d got=%0d want=7", use_clr, got_q[got_base]); end
        end
    endtask

    task automatic test_random();
        int w, nb;
        rnd_rdy = 1'b1;
        for (int r = 0; r < 8; r++) begin
            model_flush();
            win_log2 = WIN_W'($urandom_range(0, (r == 7) ? 7 : 3));
            w  = (int'(win_log2) > MAXW) ? MAXW : int'(win_log2);
            nb = (1 << w) * int'($urandom_range(1, 3));
            for (int i = 0; i < nb; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_beat(rand_beat());
            end
            wait_outputs(exp_q.size());
            checks++; if (got_q.size() - got_base !== exp_q.size()) begin errors++; $display("FAIL rnd_count r=%0d got=%0d want=%0d", r, got_q.size() - got_base, exp_q.size()); end
            for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++) begin
                checks++; if (got_q[got_base+i] !== exp_q[i]) begin errors++; $display("FAIL rnd_data r=%0d i=%0d got=%0d want=%0d", r, i, got_q[got_base+i], exp_q[i]); end
            end
        end
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_negative();
        test_extremes();
        test_window();
        test_clamp();
        test_back_to_back();
        test_abort(1'b0);
        test_abort(1'b1);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avg_pipe.md
Name: avg_pipe

Overview:
- Parametrised streaming signed averager. Each accepted beat carries NUM_IN signed WIDTH-bit samples. They are summed in a registered adder tree and optionally accumulated over 2^win_log2 beats.
- The total is divided by an arithmetic right shift and presented on a valid/ready output register.
- Successor to the fixed 8-input combinational averager in the datapath library: pipelined, with runtime window length and backpressure.

Parameters:
- WIDTH, 16, sample and output width in bits (signed two's complement).
- NUM_IN, 8, samples per beat; power of two, 2..64.
- MAX_WIN_LOG2, 4, largest supported log2 window length in beats.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous active-high reset.
- clr  in  1  synchronous flush: drops the partial window and all in-flight tree data.
- win_log2  in  clog2(MAX_WIN_LOG2+1)  log2 of beats per output.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  NUM_IN*WIDTH  packed samples; sample k is bits [k*WIDTH +: WIDTH].
- out_valid  out  1  average valid.
- out_ready  in  1  consumer accepts the average.
- out_data  out  WIDTH  signed average.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Derived widths: LOG2N = clog2(NUM_IN). SUM_W = WIDTH + LOG2N + MAX_WIN_LOG2.
  - Every sample is sign-extended to SUM_W before the first add.
  - No intermediate overflow is possible.
- Reset values: in_ready = 0 while RST is high, then 1. out_valid = 0. out_data = 0. Tree valids = 0. Accumulator = 0. Beat counter = 0.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result transfers when out_valid && out_ready.
  - stall = out_valid && !out_ready.
  - in_ready = !stall && !RST.
  - While stall is high, every pipeline register holds. out_data is stable while out_valid is high.
- Adder tree: LOG2N registered stages, each pairwise-summing the previous stage. A valid bit travels with the data.
- Accumulate stage:
  - On a tree-valid, acc <= (cnt == 0 ? tree_sum : acc + tree_sum), and cnt increments.
  - win_log2 is latched into win_q on the first beat of each window (cnt == 0). Changes mid-window take effect from the next window.
  - When cnt reaches 2^win_q - 1 and a tree-valid arrives, the window is complete: cnt wraps to 0 and the complete total goes to the output stage.
- Output stage:
  - out_data <= (total >>> (LOG2N + win_q))[WIDTH-1:0], where >>> is an arithmetic shift (floor toward minus infinity).
  - out_valid is set in the same cycle.
  - The result always fits in WIDTH bits, so no saturation is needed.
- Latency: with win_log2 = 0, a beat accepted at edge t gives out_valid at edge t+LOG2N+2 (5 cycles for NUM_IN = 8). For longer windows, the latency is counted from the last beat of the window.
- Throughput: one beat per cycle with no stalls.
- Boundary conditions:
  - clr: clears tree valids, acc, cnt and out_valid the next edge. It has priority over an accept in the same cycle.
  - RST mid-window: partial data is discarded, with no spurious out_valid.
  - Simultaneous transfer and new result: the output register reloads in the same edge.
  - win_log2 > MAX_WIN_LOG2 is clamped to MAX_WIN_LOG2.

Optional Feature:
- Macro: AVG_ROUND_EN.
- Defined: before the shift, add 2^(s-1), where s = LOG2N + win_q. This gives round-half-up toward plus infinity.
- Not defined: pure floor, and the add logic is absent.
- Latency is identical either way.

Decomposition:
- Package avg_pkg holds:
  - function clog2;
  - default constants for WIDTH, NUM_IN and MAX_WIN_LOG2;
  - localparam formulas for LOG2N and SUM_W.
- Sub-module avg_add_stage #(IN_W, PAIRS):
  - one registered pairwise-add level with valid and hold (stall) enable;
  - instantiated LOG2N times via generate.

Test Plan (WIDTH=16, NUM_IN=8, MAX_WIN_LOG2=4):
- All eight samples = 100, win_log2 = 0, out_ready = 1 -> out_data = 100, out_valid high exactly 5 cycles after accept.
- Samples -1, -2, ..., -8 (sum -36), win_log2 = 0 -> out_data = -5. With AVG_ROUND_EN -> -4.
- Max and min: all 32767 -> 32767. All -32768 -> -32768. No wrap.
- win_log2 = 2, four beats with all samples 10, 20, 30, 40 -> one out_valid pulse with out_data = 25. No output after beats 1–3.
- Backpressure: out_ready = 0 with 6 back-to-back beats, win_log2 = 0 -> in_ready drops after the first result, no beat is lost, and out_data stays stable. Releasing out_ready yields 6 results in order.
- Reset/clr mid-window: win_log2 = 3, 5 beats sent, then RST (or clr) asserted 1 cycle -> no out_valid. A fresh 8-beat window of all 7 -> out_data = 7.
